// File: rtl/perceptron_train_engine.sv
// Multi-cycle perceptron weight-row trainer: read row, apply saturating +/-1 updates LANES per beat, write back.
// Optional PERCEPTRON_TRAIN_STATS_EN adds saturating train/skip completion counters.
module perceptron_train_engine #(
   parameter int NUM_WEIGHTS = 48,
   parameter int WEIGHT_W    = 3,
   parameter int LANES       = 8,
   parameter int IDX_W       = 7,
   parameter int SUM_W       = 9,
   parameter int THETA       = 10
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [IDX_W-1:0]                req_idx,
   input  logic [NUM_WEIGHTS-1:0]          req_hist,
   input  logic                            req_outcome,
   input  logic                            req_pred,
   input  logic [SUM_W-1:0]                req_sum,
   output logic                            mem_rd_en,
   output logic [IDX_W-1:0]                mem_rd_addr,
   input  logic [NUM_WEIGHTS*WEIGHT_W-1:0] mem_rd_data,
   output logic                            mem_wr_en,
   output logic [IDX_W-1:0]                mem_wr_addr,
   output logic [NUM_WEIGHTS*WEIGHT_W-1:0] mem_wr_data,
   output logic                            done,
   output logic                            trained
`ifdef PERCEPTRON_TRAIN_STATS_EN
   ,
   output logic [15:0]                     stat_train_cnt,
   output logic [15:0]                     stat_skip_cnt
`endif
);

   localparam int ROW_W     = NUM_WEIGHTS * WEIGHT_W;
   localparam int K         = NUM_WEIGHTS / LANES;
   localparam int BEAT_W    = (K > 1) ? $clog2(K) : 1;
   localparam int LANE_BITS = LANES * WEIGHT_W;
   localparam logic [BEAT_W-1:0]          K_LAST = BEAT_W'(K - 1);
   localparam logic signed [WEIGHT_W-1:0] W_MAX  = {1'b0, {(WEIGHT_W-1){1'b1}}};
   localparam logic signed [WEIGHT_W-1:0] W_MIN  = {1'b1, {(WEIGHT_W-1){1'b0}}};
   localparam logic [ROW_W-1:0]           LANE_MASK = ROW_W'({LANE_BITS{1'b1}});

   typedef enum logic [2:0] {IDLE, SKIP, RD, CAP, UPD, WR} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q;
   logic [NUM_WEIGHTS-1:0]   hist_q;
   logic                     outcome_q;
   logic [ROW_W-1:0]         row_q, upd_row, row_sh;
   logic [BEAT_W-1:0]        beat_q;
   logic signed [SUM_W:0]    sum_ext;
   logic [SUM_W:0]           sum_mag;
   logic                     train;
   logic [NUM_WEIGHTS-1:0]   hist_sh;
   logic [LANES-1:0]         lane_x;
   logic [LANE_BITS-1:0]     lane_old, lane_new;
   logic signed [WEIGHT_W-1:0] w;

   // Magnitude is taken one bit wider so the most negative sum maps to a positive value.
   assign sum_ext = {req_sum[SUM_W-1], req_sum};
   assign sum_mag = sum_ext[SUM_W] ? -sum_ext : sum_ext;
   assign train   = (req_outcome != req_pred) || (sum_mag <= (SUM_W+1)'(THETA));

   assign req_ready   = (state_q == IDLE);
   assign mem_rd_addr = idx_q;
   assign mem_wr_addr = idx_q;
   assign mem_wr_data = row_q;

   always_comb begin
      // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latches).
      state_d   = state_q;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      done      = 1'b0;
      trained   = 1'b0;
      unique case (state_q)
         IDLE: if (req_valid) state_d = train ? RD : SKIP;
         SKIP: begin done = 1'b1; state_d = IDLE; end
         RD:   begin mem_rd_en = 1'b1; state_d = CAP; end
         CAP:  state_d = UPD;
         UPD:  if (beat_q == K_LAST) state_d = WR;
         WR:   begin mem_wr_en = 1'b1; done = 1'b1; trained = 1'b1; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   // Current beat's lanes are shifted down to position 0, updated, then merged back in place.
   always_comb begin
      hist_sh  = hist_q >> (int'(beat_q) * LANES);
      lane_x   = hist_sh[LANES-1:0];
      if (beat_q == '0) lane_x[0] = 1'b1;
      row_sh   = row_q >> (int'(beat_q) * LANE_BITS);
      lane_old = row_sh[LANE_BITS-1:0];
      lane_new = lane_old;
      w        = '0;
      for (int l = 0; l < LANES; l++) begin
         w = lane_old[l*WEIGHT_W +: WEIGHT_W];
         if (lane_x[l] == outcome_q) begin
            if (w != W_MAX) w = w + WEIGHT_W'(1);
         end else if (w != W_MIN) begin
            w = w - WEIGHT_W'(1);
         end
         lane_new[l*WEIGHT_W +: WEIGHT_W] = w;
      end
      upd_row = (row_q & ~(LANE_MASK << (int'(beat_q) * LANE_BITS)))
              | (ROW_W'(lane_new) << (int'(beat_q) * LANE_BITS));
   end

   // NOTE: state uses non-blocking assignments; the row register is plain flops, so it is reset too.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         hist_q    <= '0;
         outcome_q <= 1'b0;
         row_q     <= '0;
         beat_q    <= '0;
      end else begin
         state_q <= state_d;
         if (req_valid && req_ready) begin
            idx_q     <= req_idx;
            hist_q    <= req_hist;
            outcome_q <= req_outcome;
         end
         if (state_q == CAP) begin
            row_q  <= mem_rd_data;
            beat_q <= '0;
         end
         if (state_q == UPD) begin
            row_q  <= upd_row;
            beat_q <= beat_q + BEAT_W'(1);
         end
      end
   end

`ifdef PERCEPTRON_TRAIN_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_train_cnt <= '0;
         stat_skip_cnt  <= '0;
      end else if (done) begin
         if (trained && stat_train_cnt != 16'hFFFF) stat_train_cnt <= stat_train_cnt + 16'd1;
         if (!trained && stat_skip_cnt != 16'hFFFF) stat_skip_cnt <= stat_skip_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_perceptron_train_engine.sv
// Self-checking bench for perceptron_train_engine: directed table, corner sequences, random vs reference model.
module tb_perceptron_train_engine;
   localparam int NW = 48, WW = 3, ROW_W = NW*WW, K = NW/8;

   logic              clk, rst_n;
   logic              req_valid, req_ready, req_outcome, req_pred;
   logic [6:0]        req_idx, mem_rd_addr, mem_wr_addr;
   logic [NW-1:0]     req_hist;
   logic [8:0]        req_sum;
   logic              mem_rd_en, mem_wr_en, done, trained;
   logic [ROW_W-1:0]  mem_rd_data, mem_wr_data;
`ifdef PERCEPTRON_TRAIN_STATS_EN
   logic [15:0]       stat_train_cnt, stat_skip_cnt;
`endif

   perceptron_train_engine dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_hist(req_hist),
      .req_outcome(req_outcome), .req_pred(req_pred), .req_sum(req_sum),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .done(done), .trained(trained)
`ifdef PERCEPTRON_TRAIN_STATS_EN
      , .stat_train_cnt(stat_train_cnt), .stat_skip_cnt(stat_skip_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Weight-table SRAM model: one-cycle read latency, preload port for the bench.
   logic [ROW_W-1:0] mem [128];
   logic             pre_en;
   logic [6:0]       pre_idx;
   logic [ROW_W-1:0] pre_data;
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (pre_en)    mem[pre_idx] <= pre_data;
   end

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [ROW_W-1:0] rep(input logic [2:0] v);
      return {NW{v}};
   endfunction

   // Reference model straight from the rules: signed integer weights clamped to [-4, 3].
   function automatic logic model_train(input logic outcome, input logic pred, input logic [8:0] sum);
      int s = int'($signed(sum));
      if (s < 0) s = -s;
      return (outcome != pred) || (s <= 10);
   endfunction

   function automatic logic [ROW_W-1:0] model_row(input logic [ROW_W-1:0] row, input logic [NW-1:0] hist,
                                                  input logic outcome);
      logic [ROW_W-1:0] r = row;
      for (int i = 0; i < NW; i++) begin
         int  wv = int'($signed(row[i*WW +: WW]));
         logic x = (i == 0) ? 1'b1 : hist[i];
         if (x == outcome) wv = (wv < 3) ? wv + 1 : 3;
         else              wv = (wv > -4) ? wv - 1 : -4;
         r[i*WW +: WW] = 3'(wv);
      end
      return r;
   endfunction

   task automatic preload(input logic [6:0] idx, input logic [ROW_W-1:0] data);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   // Watches from the current negedge (cycle T+1) until done or a 30-cycle budget expires.
   task automatic observe(output int done_cyc, output logic tr, output int rd_cnt, output int rd_cyc,
                          output logic [6:0] rd_addr, output int wr_cnt, output logic [6:0] wr_addr,
                          output logic [ROW_W-1:0] wr_data, output int overlap);
      done_cyc = -1; tr = 1'bx; rd_cnt = 0; rd_cyc = -1; rd_addr = 'x;
      wr_cnt = 0; wr_addr = 'x; wr_data = 'x; overlap = 0;
      for (int n = 1; n <= 30; n++) begin
         if (mem_rd_en) begin rd_cnt++; rd_cyc = n; rd_addr = mem_rd_addr; end
         if (mem_wr_en) begin wr_cnt++; wr_addr = mem_wr_addr; wr_data = mem_wr_data; end
         if (mem_rd_en && mem_wr_en) overlap++;
         if (done) begin done_cyc = n; tr = trained; break; end
         @(negedge clk);
      end
   endtask

   task automatic run_req(input string tag, input logic [6:0] idx, input logic [NW-1:0] hist,
                          input logic outcome, input logic pred, input logic [8:0] sum,
                          input logic [ROW_W-1:0] init_row, input logic exp_train,
                          input logic [ROW_W-1:0] exp_row);
      int d, rc, rcy, wc, ov;
      logic tr;
      logic [6:0] ra, wa;
      logic [ROW_W-1:0] wd;
      preload(idx, init_row);
      @(negedge clk);
      req_idx = idx; req_hist = hist; req_outcome = outcome; req_pred = pred; req_sum = sum;
      req_valid = 1'b1;
      check({tag, " ready_at_accept"}, req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      observe(d, tr, rc, rcy, ra, wc, wa, wd, ov);
      check({tag, " done_cycle"}, d, exp_train ? 3 + K : 1);
      check({tag, " trained"}, tr, exp_train);
      check({tag, " rd_count"}, rc, exp_train ? 1 : 0);
      check({tag, " wr_count"}, wc, exp_train ? 1 : 0);
      check({tag, " rd_wr_overlap"}, ov, 0);
      if (exp_train) begin
         check({tag, " rd_cycle"}, rcy, 1);
         check({tag, " rd_addr"}, ra, idx);
         check({tag, " wr_addr"}, wa, idx);
         check({tag, " wr_data"}, wd, exp_row);
      end
      @(negedge clk);
      check({tag, " ready_after_done"}, req_ready, 1'b1);
   endtask

   typedef struct {
      logic [6:0]       idx;
      logic [NW-1:0]    hist;
      logic             outcome;
      logic             pred;
      logic [8:0]       sum;
      logic [ROW_W-1:0] init_row;
      logic             exp_train;
      logic [ROW_W-1:0] exp_row;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input logic [6:0] idx, input logic [NW-1:0] hist, input logic outcome,
                          input logic pred, input logic [8:0] sum, input logic [ROW_W-1:0] init_row,
                          input logic exp_train, input logic [ROW_W-1:0] exp_row);
      vec_t v;
      v.idx = idx; v.hist = hist; v.outcome = outcome; v.pred = pred; v.sum = sum;
      v.init_row = init_row; v.exp_train = exp_train; v.exp_row = exp_row;
      vq.push_back(v);
   endtask

   initial begin
      logic [ROW_W-1:0] sat_low, mixed, row_a, row_b, rr;
      logic [NW-1:0]    hh;
      logic             oo, pp;
      logic [8:0]       ss;
      int d, rc, rcy, wc, ov, busy_bad, wr_seen;
      logic tr;
      logic [6:0] ra, wa;
      logic [ROW_W-1:0] wd;

      rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; req_hist = '0; req_outcome = 1'b0;
      req_pred = 1'b0; req_sum = '0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
      repeat (3) @(negedge clk);
      check("reset req_ready", req_ready, 1'b1);
      check("reset mem_rd_en", mem_rd_en, 1'b0);
      check("reset mem_wr_en", mem_wr_en, 1'b0);
      check("reset done", done, 1'b0);
      check("reset trained", trained, 1'b0);
      check("reset mem_wr_data", mem_wr_data, '0);
      check("reset mem_rd_addr", mem_rd_addr, '0);
      rst_n = 1'b1;

      sat_low = rep(3'b100);
      sat_low[2:0] = 3'b101;
      mixed = rep(3'b111);
      for (int i = 1; i < NW; i += 2) mixed[i*WW +: WW] = 3'b001;

      add_vec(7'd5,  '1, 1'b1, 1'b0, 9'(-20),  rep(3'b010), 1'b1, rep(3'b011));
      add_vec(7'd6,  '1, 1'b1, 1'b1, 9'(0),    rep(3'b011), 1'b1, rep(3'b011));
      add_vec(7'd7,  '0, 1'b1, 1'b1, 9'(0),    rep(3'b100), 1'b1, sat_low);
      add_vec(7'd8,  '1, 1'b1, 1'b1, 9'(11),   rep(3'b000), 1'b0, rep(3'b000));
      add_vec(7'd9,  '1, 1'b1, 1'b1, 9'(10),   rep(3'b000), 1'b1, rep(3'b001));
      add_vec(7'd10, '1, 1'b1, 1'b1, 9'(-10),  rep(3'b000), 1'b1, rep(3'b001));
      add_vec(7'd11, '1, 1'b1, 1'b1, 9'(-256), rep(3'b000), 1'b0, rep(3'b000));
      add_vec(7'd12, '1, 1'b0, 1'b0, 9'(-11),  rep(3'b000), 1'b0, rep(3'b000));
      add_vec(7'd13, 48'h5555_5555_5555, 1'b0, 1'b0, 9'(0), rep(3'b000), 1'b1, mixed);

      foreach (vq[k])
         run_req($sformatf("vec%0d", k), vq[k].idx, vq[k].hist, vq[k].outcome, vq[k].pred,
                 vq[k].sum, vq[k].init_row, vq[k].exp_train, vq[k].exp_row);

      // Back-pressure: second request held valid from T+1, must wait until T+10.
      row_a = rep(3'b010);
      row_b = rep(3'b110);
      preload(7'd20, row_a);
      preload(7'd21, row_b);
      @(negedge clk);
      req_idx = 7'd20; req_hist = '1; req_outcome = 1'b1; req_pred = 1'b0; req_sum = 9'(-20);
      req_valid = 1'b1;
      busy_bad = 0; wr_seen = 0; wd = '0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (n == 1) begin
            req_idx = 7'd21; req_hist = 48'h0F0F_00FF_1234; req_outcome = 1'b0;
            req_pred = 1'b0; req_sum = 9'(3);
         end
         if (req_ready) busy_bad++;
         if (mem_wr_en) begin wr_seen++; wd = mem_wr_data; end
      end
      check("bp ready_low_T1_T9", busy_bad, 0);
      check("bp first_done_T9", done, 1'b1);
      check("bp first_wr_count", wr_seen, 1);
      check("bp first_wr_data", wd, model_row(row_a, '1, 1'b1));
      @(negedge clk);
      check("bp ready_T10", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      observe(d, tr, rc, rcy, ra, wc, wa, wd, ov);
      check("bp second_done_cycle", d, 3 + K);
      check("bp second_rd_addr", ra, 7'd21);
      check("bp second_wr_addr", wa, 7'd21);
      check("bp second_wr_data", wd, model_row(row_b, 48'h0F0F_00FF_1234, 1'b0));
      @(negedge clk);

      // Reset during UPD beat 3 (cycle T+6): request discarded, no write-back.
      row_a = rep(3'b001);
      preload(7'd30, row_a);
      @(negedge clk);
      req_idx = 7'd30; req_hist = '1; req_outcome = 1'b1; req_pred = 1'b0; req_sum = 9'(0);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wr_seen = 0;
      for (int n = 2; n <= 6; n++) begin
         @(negedge clk);
         if (mem_wr_en) wr_seen++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("rst ready_next_cycle", req_ready, 1'b1);
      check("rst no_done", done, 1'b0);
      if (mem_wr_en) wr_seen++;
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (mem_wr_en) wr_seen++;
      end
      check("rst no_write_back", wr_seen, 0);
      check("rst row_untouched", mem[30], row_a);
      run_req("rst follow_up", 7'd31, '1, 1'b1, 1'b0, 9'(5), rep(3'b000), 1'b1, rep(3'b001));

      // Random requests against the reference model.
      for (int k = 0; k < 40; k++) begin
         hh = NW'({$urandom, $urandom});
         oo = 1'($urandom_range(0, 1));
         pp = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) ss = 9'(int'($urandom_range(0, 30)) - 15);
         else                           ss = 9'(int'($urandom_range(0, 511)) - 256);
         for (int i = 0; i < NW; i++) rr[i*WW +: WW] = 3'($urandom_range(0, 7));
         run_req($sformatf("rand%0d", k), 7'($urandom_range(0, 127)), hh, oo, pp, ss, rr,
                 model_train(oo, pp, ss), model_row(rr, hh, oo));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
